// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the byte-bus arbiter.
package mem_bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Upper two RAM address bits equal to this code select the IO space.
    localparam logic [1:0] IO_REGION = 2'b11;
    localparam int         IO_SEL_W  = 3;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side handshake plus RAM/IO slave bus of the arbiter.
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int RAM_ADDR_WIDTH = 17
);
    import mem_bus_pkg::*;

    logic [NUM_MASTERS-1:0]      m_req_in;
    logic [32*NUM_MASTERS-1:0]   m_a_in;
    logic [NUM_MASTERS-1:0]      m_wr_in;
    logic [8*NUM_MASTERS-1:0]    m_dout_in;
    logic [NUM_MASTERS-1:0]      m_gnt_out;
    logic [NUM_MASTERS-1:0]      m_rvalid_out;
    logic [7:0]                  m_din_out;

    logic                        ram_en_out;
    logic                        ram_r_nw_out;
    logic [RAM_ADDR_WIDTH-1:0]   ram_a_out;
    logic [7:0]                  ram_d_out;
    logic [7:0]                  ram_d_in;

    logic                        io_en_out;
    logic                        io_wr_out;
    logic [IO_SEL_W-1:0]         io_sel_out;
    logic [7:0]                  io_d_out;
    logic [7:0]                  io_d_in;

    // Arbiter side.
    modport slave (
        input  m_req_in, m_a_in, m_wr_in, m_dout_in, ram_d_in, io_d_in,
        output m_gnt_out, m_rvalid_out, m_din_out,
               ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
               io_en_out, io_wr_out, io_sel_out, io_d_out
    );

    // Masters and memory/IO models side.
    modport master (
        output m_req_in, m_a_in, m_wr_in, m_dout_in, ram_d_in, io_d_in,
        input  m_gnt_out, m_rvalid_out, m_din_out,
               ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out,
               io_en_out, io_wr_out, io_sel_out, io_d_out
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_onehot,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_j;

    // Scan i_last+1 .. i_last+N so i_last itself is the lowest priority.
    always_comb begin
        o_onehot = '0;
        o_valid  = 1'b0;
        w_j      = '0;
        for (int k = 1; k <= N; k++) begin
            if (!o_valid) begin
                w_j = IDX_W'((int'(i_last) + k) % N);
                if (i_req[w_j]) begin
                    o_onehot[w_j] = 1'b1;
                    o_valid       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Byte-bus arbiter: round-robin ownership with burst cap and debug pause,
// RAM/IO decode of the owner's beat and one-cycle read return.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int MAX_BURST      = 16,
    parameter int PAUSE_MASTER   = 0
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           pause_in,
    mem_bus_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [IDX_W-1:0]       PAUSE_IDX  = IDX_W'(PAUSE_MASTER);
    localparam logic [NUM_MASTERS-1:0] PAUSE_MASK = NUM_MASTERS'(1) << PAUSE_MASTER;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_owner, w_owner_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_rd_pend;
    logic [IDX_W-1:0]        r_rd_owner;
    logic                    r_rd_is_io;
    logic [7:0]              r_din;

    logic [NUM_MASTERS-1:0]  w_elig;
    logic [NUM_MASTERS-1:0]  w_pick_oh;
    logic                    w_pick_valid;
    logic [IDX_W-1:0]        w_pick_idx;
    logic [RAM_ADDR_WIDTH:0] w_a;
    logic                    w_wr;
    logic [7:0]              w_dout;
    logic                    w_req_own;
    logic                    w_beat;
    logic                    w_is_io;
    logic                    w_release;
    logic [7:0]              w_din;

    assign w_elig = pause_in ? (bus.m_req_in & PAUSE_MASK) : bus.m_req_in;

    // r_owner doubles as last_owner while idle.
    rr_pick #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rr_pick (
        .i_req    (w_elig),
        .i_last   (r_owner),
        .o_onehot (w_pick_oh),
        .o_valid  (w_pick_valid)
    );

    // Encode the picker's one-hot result to an owner index.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_pick_oh[i]) w_pick_idx = IDX_W'(i);
        end
    end

    // Route the owner's request, address, direction and write data.
    // Address bits above the IO-region code are never looked at.
    always_comb begin
        w_a       = '0;
        w_wr      = 1'b0;
        w_dout    = '0;
        w_req_own = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_a       = bus.m_a_in[32*i +: RAM_ADDR_WIDTH+1];
                w_wr      = bus.m_wr_in[i];
                w_dout    = bus.m_dout_in[8*i +: 8];
                w_req_own = bus.m_req_in[i];
            end
        end
    end

    assign w_beat    = (r_state == ST_BUSY) && w_req_own;
    assign w_is_io   = (w_a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == IO_REGION);
    assign w_release = (r_state == ST_BUSY) &&
                       (!w_req_own ||
                        (w_beat && (r_cnt == CNT_W'(MAX_BURST-1))) ||
                        (pause_in && (r_owner != PAUSE_IDX)));

    // Next state, next owner and burst counter; a release hands over in the
    // same edge so back-to-back owners see no idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    w_cnt_nxt = '0;
                    if (w_pick_valid) w_owner_nxt = w_pick_idx;
                    else              w_state_nxt = ST_IDLE;
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
            r_owner <= IDX_W'(NUM_MASTERS-1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Remember who issued a read so the return lands even after handover.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= '0;
            r_rd_is_io <= 1'b0;
            r_din      <= '0;
        end else begin
            r_rd_pend  <= w_beat && !w_wr;
            r_rd_owner <= r_owner;
            r_rd_is_io <= w_is_io;
            r_din      <= w_din;
        end
    end

    assign w_din = r_rd_pend ? (r_rd_is_io ? bus.io_d_in : bus.ram_d_in) : r_din;

    assign bus.m_gnt_out    = (r_state == ST_BUSY) ? (NUM_MASTERS'(1) << r_owner) : '0;
    assign bus.m_rvalid_out = r_rd_pend ? (NUM_MASTERS'(1) << r_rd_owner) : '0;
    assign bus.m_din_out    = w_din;

    assign bus.ram_en_out   = w_beat && !w_is_io;
    assign bus.ram_r_nw_out = !w_wr;
    assign bus.ram_a_out    = w_a[RAM_ADDR_WIDTH-1:0];
    assign bus.ram_d_out    = w_dout;

    assign bus.io_en_out    = w_beat && w_is_io;
    assign bus.io_wr_out    = w_wr;
    assign bus.io_sel_out   = w_a[IO_SEL_W-1:0];
    assign bus.io_d_out     = w_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a read-return scoreboard.
module tb_mem_bus_arbiter;

    localparam int NM  = 2;
    localparam int RAW = 17;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pause = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    rd_exp_t sb[$];

    mem_bus_arbiter_if #(.NUM_MASTERS(NM), .RAM_ADDR_WIDTH(RAW)) bus ();

    mem_bus_arbiter #(
        .NUM_MASTERS(NM), .RAM_ADDR_WIDTH(RAW), .MAX_BURST(4), .PAUSE_MASTER(0)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .pause_in (pause),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_val(input logic [RAW-1:0] a);
        if (a == RAW'(17'h00010)) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] io_val(input logic [2:0] s);
        return {5'b11000, s};
    endfunction

    // Synchronous RAM and IO models: data follows the address by one cycle.
    always @(posedge clk) begin
        bus.ram_d_in <= ram_val(bus.ram_a_out);
        bus.io_d_in  <= io_val(bus.io_sel_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a read beat seen this cycle must return exactly next cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (sb.size() > 0) begin
                rd_exp_t e;
                e = sb.pop_front();
                chk("rvalid", 32'(bus.m_rvalid_out), 32'(1) << e.idx);
                chk("rdata", 32'(bus.m_din_out), 32'(e.data));
            end else begin
                chk("rvalid_quiet", 32'(bus.m_rvalid_out), 32'd0);
            end
            for (int i = 0; i < NM; i++) begin
                if (bus.m_req_in[i] && bus.m_gnt_out[i] && !bus.m_wr_in[i]) begin
                    logic [31:0] a;
                    rd_exp_t     e;
                    a      = bus.m_a_in[32*i +: 32];
                    e.idx  = i;
                    e.data = (a[RAW:RAW-1] == 2'b11) ? io_val(a[2:0]) : ram_val(a[RAW-1:0]);
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic wait_gnt(input int m, input string tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.m_gnt_out[m]) break;
        end
        chk(tag, 32'(bus.m_gnt_out), 32'(1) << m);
    endtask

    initial begin
        bus.m_req_in  = '0;
        bus.m_a_in    = '0;
        bus.m_wr_in   = '0;
        bus.m_dout_in = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.m_gnt_out), 0);
        chk("rst_rvalid", 32'(bus.m_rvalid_out), 0);
        chk("rst_din", 32'(bus.m_din_out), 0);
        chk("rst_ram_en", 32'(bus.ram_en_out), 0);
        chk("rst_io_en", 32'(bus.io_en_out), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_gnt", 32'(bus.m_gnt_out), 0);

        // Both masters stream reads: 4-beat bursts alternating, master 0 first
        @(posedge clk); #1;
        bus.m_a_in   = {32'h0000_0010, 32'h0000_0020};
        bus.m_req_in = 2'b11;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("burst_gnt", 32'(bus.m_gnt_out), ((k / 4) % 2 == 0) ? 32'd1 : 32'd2);
        end
        @(posedge clk); #1 bus.m_req_in = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("burst_end_gnt", 32'(bus.m_gnt_out), 0);

        // Master 1 single RAM read of 0x00010
        @(posedge clk); #1 bus.m_req_in = 2'b10;
        wait_gnt(1, "rd_gnt");
        chk("rd_ram_en", 32'(bus.ram_en_out), 1);
        chk("rd_io_en", 32'(bus.io_en_out), 0);
        chk("rd_ram_a", 32'(bus.ram_a_out), 32'h10);
        chk("rd_r_nw", 32'(bus.ram_r_nw_out), 1);
        @(posedge clk); #1 bus.m_req_in = 2'b00;
        @(negedge clk);
        chk("rd_rvalid", 32'(bus.m_rvalid_out), 2);
        chk("rd_data", 32'(bus.m_din_out), 32'hA5);
        @(negedge clk);
        chk("rd_hold", 32'(bus.m_din_out), 32'hA5);

        // Master 0 IO write of 0x5A to 0x30004
        @(posedge clk); #1;
        bus.m_a_in[31:0]   = 32'h0003_0004;
        bus.m_wr_in        = 2'b01;
        bus.m_dout_in[7:0] = 8'h5A;
        bus.m_req_in       = 2'b01;
        wait_gnt(0, "wr_gnt");
        chk("wr_io_en", 32'(bus.io_en_out), 1);
        chk("wr_io_wr", 32'(bus.io_wr_out), 1);
        chk("wr_io_sel", 32'(bus.io_sel_out), 32'h4);
        chk("wr_ram_en", 32'(bus.ram_en_out), 0);
        chk("wr_io_d", 32'(bus.io_d_out), 32'h5A);
        @(posedge clk); #1 bus.m_req_in = 2'b00;
        @(negedge clk);
        chk("wr_no_rvalid", 32'(bus.m_rvalid_out), 0);
        @(negedge clk);

        // Pause while master 1 owns with a read in flight
        @(posedge clk); #1;
        bus.m_wr_in     = 2'b00;
        bus.m_a_in      = {32'h0000_0010, 32'h0000_0020};
        bus.m_req_in    = 2'b11;
        wait_gnt(1, "pz_gnt1");
        pause = 1'b1;
        @(negedge clk);
        chk("pz_rvalid", 32'(bus.m_rvalid_out), 2);
        chk("pz_data", 32'(bus.m_din_out), 32'hA5);
        chk("pz_gnt0", 32'(bus.m_gnt_out), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("pz_hold_gnt0", 32'(bus.m_gnt_out), 1);
        end
        @(posedge clk); #1 bus.m_req_in = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("pz_m1_blocked", 32'(bus.m_gnt_out), 0);
        @(negedge clk);
        chk("pz_m1_blocked2", 32'(bus.m_gnt_out), 0);
        pause = 1'b0;
        @(negedge clk);
        chk("pz_resume_gnt1", 32'(bus.m_gnt_out), 2);
        @(posedge clk); #1 bus.m_req_in = 2'b00;
        @(negedge clk);
        @(negedge clk);

        // Reset pulse during a pending read
        @(posedge clk); #1 bus.m_req_in = 2'b01;
        wait_gnt(0, "rr_gnt0");
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("rr_gnt", 32'(bus.m_gnt_out), 0);
        chk("rr_rvalid", 32'(bus.m_rvalid_out), 0);
        chk("rr_din", 32'(bus.m_din_out), 0);
        chk("rr_ram_en", 32'(bus.ram_en_out), 0);
        bus.m_req_in = 2'b11;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rr_no_early_gnt", 32'(bus.m_gnt_out), 0);
        @(negedge clk);
        chk("rr_first_gnt0", 32'(bus.m_gnt_out), 1);

        // IO read from master 1; upper address bits must not affect decode
        @(posedge clk); #1;
        bus.m_a_in[63:32] = 32'hFFF3_0005;
        bus.m_req_in      = 2'b10;
        wait_gnt(1, "io_gnt1");
        chk("io_en", 32'(bus.io_en_out), 1);
        chk("io_ram_en", 32'(bus.ram_en_out), 0);
        chk("io_sel", 32'(bus.io_sel_out), 32'h5);
        @(posedge clk); #1 bus.m_req_in = 2'b00;
        @(negedge clk);
        chk("io_rvalid", 32'(bus.m_rvalid_out), 2);
        chk("io_data", 32'(bus.m_din_out), 32'hC5);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL take parameter NUM_MASTERS, default 2: number of byte-bus masters, range 2..8.
REQ-002 SHALL take parameter RAM_ADDR_WIDTH, default 17: RAM address width; IO region is a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.
REQ-003 SHALL take parameter MAX_BURST, default 16: maximum consecutive beats per grant before forced rotation.
REQ-004 SHALL take parameter PAUSE_MASTER, default 0: index of the debug master favoured by pause_in.
REQ-005 SHALL have clk_in  input  1  system clock; all state on rising edge.
REQ-006 SHALL have rst_n_in  input  1  asynchronous, active-low reset.
REQ-007 SHALL have pause_in  input  1  debug break; only PAUSE_MASTER may own the bus while high.
REQ-008 SHALL have m_req_in  input  NUM_MASTERS  per-master beat request, one byte per cycle.
REQ-009 SHALL have m_a_in  input  32*NUM_MASTERS  packed byte addresses, master i at [32i+31:32i].
REQ-010 SHALL have m_wr_in  input  NUM_MASTERS  1=write, 0=read.
REQ-011 SHALL have m_dout_in  input  8*NUM_MASTERS  write data.
REQ-012 SHALL have m_gnt_out  output  NUM_MASTERS  one-hot registered owner; beat accepted when req&gnt.
REQ-013 SHALL have m_rvalid_out  output  NUM_MASTERS  one-cycle pulse: read data for that master on m_din_out.
REQ-014 SHALL have m_din_out  output  8  shared read data.
REQ-015 SHALL have ram_en_out, ram_r_nw_out (1), ram_a_out (RAM_ADDR_WIDTH), ram_d_out (8) outputs and ram_d_in (8) input; RAM read data valid one cycle after address.
REQ-016 SHALL have io_en_out, io_wr_out (1), io_sel_out (3), io_d_out (8) outputs and io_d_in (8) input; same one-cycle read latency.

Function
REQ-017 States IDLE, BUSY; IDLE drives gnt=0, ram_en=0, io_en=0.
REQ-018 IDLE with any eligible req: next edge -> BUSY, owner = first eligible index after last_owner, round-robin, wrapping NUM_MASTERS-1 -> 0.
REQ-019 Eligible: all req'ing masters when pause_in=0; only PAUSE_MASTER when pause_in=1.
REQ-020 BUSY: owner's a/wr/dout drive the slave bus combinationally; beat issued when owner req=1; ram_en = beat & ~IO region; io_en = beat & IO region; ram_r_nw = ~wr; io_sel = a[2:0].
REQ-021 Beat counter (width clog2(MAX_BURST)+1) increments per beat, clears on owner change.
REQ-022 Release at edge when owner req=0, or counter reaches MAX_BURST-1 with a beat, or pause_in=1 and owner != PAUSE_MASTER; release -> new owner per REQ-018 in same edge (no bubble) else IDLE.
REQ-023 Forced rotation with only the current owner requesting: owner retained, counter cleared.
REQ-024 Read beat: registered rd_owner and rd_is_io; next cycle m_rvalid_out[rd_owner]=1, m_din_out = rd_is_io ? io_d_in : ram_d_in; delivered even if ownership changed or pause_in rose.
REQ-025 Writes produce no rvalid; m_din_out holds last value when no rvalid.
REQ-026 pause_in rising while PAUSE_MASTER already owns: no release; pause_in falling: normal rotation resumes at next release.
REQ-027 Address bits above RAM_ADDR_WIDTH ignored for decode.

Reset
REQ-028 rst_n_in low, asynchronously: state=IDLE, gnt=0, rvalid=0, m_din_out=0, counter=0, last_owner=NUM_MASTERS-1 (first grant to master 0), ram_en=io_en=0.
REQ-029 Reset mid-read SHALL cancel the pending rvalid; first post-reset grant earliest one edge after rst_n_in deasserts.

Structure
REQ-030 Package mem_bus_pkg SHALL hold the state typedef, IO region code 2'b11, IO select width 3.
REQ-031 Round-robin picker SHALL be sub-module rr_pick (req mask, last index -> one-hot, valid), combinational.

Verification
REQ-032 Masters 0,1 request continuously, MAX_BURST=4 -> gnt 0 for 4 beats, then 1 for 4, alternating, no idle cycle.
REQ-033 Master 1 reads 0x00010 (RAM holds 0xA5) -> cycle after beat: rvalid[1]=1, m_din_out=0xA5, ram_en=1, io_en=0.
REQ-034 Master 0 writes 0x5A to 0x30004 -> io_en=1, io_wr=1, io_sel=3'b100, ram_en=0, no rvalid.
REQ-035 Master 1 owns, read issued, pause_in rises -> rvalid[1] next cycle with correct data, then gnt moves to PAUSE_MASTER 0; master 1 ungranted until pause_in falls.
REQ-036 rst_n_in pulsed low during BUSY with pending read -> gnt=0, rvalid=0 immediately; after release master 0 granted first.
